fwd_bypass_net: RTL

Parametrised forwarding network for the RISC-V pipeline. It replaces fixed 3-input forwarding muxes with a DEPTH-slot history of in-flight register writes and NUM_RD independent read ports. Each read port returns the youngest in-flight value for its source register, or the register-file value if there is none. It also tracks load results whose data is not yet available and raises a load-use stall. The block sits between ID/EX operand fetch and the ALU operand inputs.

---
 rtl/fwd_bypass_net.sv | 117 +++++++++++
 1 files changed

// File: rtl/fwd_bypass_net.sv
// rtl/fwd_bypass_net.sv - in-flight register write history with multi-port operand forwarding
//
// Purpose: keeps a DEPTH-slot history of register writes that have not yet reached the
// register file (slot 0 youngest). Each of NUM_RD read ports returns the youngest matching
// in-flight value, or the register-file value when nothing matches. A load whose data is
// not yet known sits pending in slot 0; a port that would forward it raises hazard_stall.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   adv                 pipeline advance; the history shifts only when high
//   flush               kill the instruction entering (adv=1) or sitting in (adv=0) slot 0
//   wr_valid/rd/data    write carried by the instruction entering slot 0
//   wr_pending          that write is a load whose data arrives later on ld_data
//   ld_data             load result for a pending slot 0 as it moves into slot 1
//   rs_addr, rf_data    per-port source register and register-file read data
//   fwd_data, fwd_sel   per-port operand and source (0 = register file, k = slot k-1)
//   hazard_stall        some port's youngest match is still pending
module fwd_bypass_net #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 3,
  parameter int NUM_RD     = 2,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         adv,
  input  logic                         flush,
  input  logic                         wr_valid,
  input  logic [REG_ADDR_W-1:0]        wr_rd,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         wr_pending,
  input  logic [DATA_WIDTH-1:0]        ld_data,
  input  logic [NUM_RD*REG_ADDR_W-1:0] rs_addr,
  input  logic [NUM_RD*DATA_WIDTH-1:0] rf_data,
  output logic [NUM_RD*DATA_WIDTH-1:0] fwd_data,
  output logic [NUM_RD*SEL_W-1:0]      fwd_sel,
  output logic                         hazard_stall
);

  logic                  valid_q [DEPTH];
  logic                  valid_d [DEPTH];
  logic                  pend_q  [DEPTH];
  logic                  pend_d  [DEPTH];
  logic [REG_ADDR_W-1:0] rd_q    [DEPTH];
  logic [REG_ADDR_W-1:0] rd_d    [DEPTH];
  logic [DATA_WIDTH-1:0] data_q  [DEPTH];
  logic [DATA_WIDTH-1:0] data_d  [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i];
      pend_d[i]  = pend_q[i];
      rd_d[i]    = rd_q[i];
      data_d[i]  = data_q[i];
    end
    if (adv) begin
      for (int i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
        pend_d[i]  = pend_q[i-1];
        rd_d[i]    = rd_q[i-1];
        data_d[i]  = data_q[i-1];
      end
      // A load leaving slot 0 picks up its data on the way out, so only slot 0 is ever pending.
      if (pend_q[0]) begin
        data_d[1] = ld_data;
        pend_d[1] = 1'b0;
      end
      // flush with adv kills only the incoming entry; the old slot 0 has already shifted.
      valid_d[0] = wr_valid & ~flush;
      rd_d[0]    = wr_rd;
      data_d[0]  = wr_data;
      pend_d[0]  = wr_pending & wr_valid & ~flush;
    end else if (flush) begin
      valid_d[0] = 1'b0;
      pend_d[0]  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      rd_q[i]   <= rd_d[i];
      data_q[i] <= data_d[i];
      if (rst) begin
        valid_q[i] <= 1'b0;
        pend_q[i]  <= 1'b0;
      end else begin
        valid_q[i] <= valid_d[i];
        pend_q[i]  <= pend_d[i];
      end
    end
  end

  logic [REG_ADDR_W-1:0] addr;
  logic [NUM_RD-1:0]     stall_term;

  always_comb begin
    fwd_data   = rf_data;
    fwd_sel    = '0;
    stall_term = '0;
    addr       = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      addr = rs_addr[p*REG_ADDR_W +: REG_ADDR_W];
      // Scan oldest to youngest so the youngest match overwrites any older one.
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (valid_q[k] && rd_q[k] == addr && addr != '0) begin
          fwd_sel[p*SEL_W +: SEL_W] = SEL_W'(k + 1);
          stall_term[p]             = pend_q[k];
          fwd_data[p*DATA_WIDTH +: DATA_WIDTH] =
              pend_q[k] ? rf_data[p*DATA_WIDTH +: DATA_WIDTH] : data_q[k];
        end
      end
    end
    hazard_stall = |stall_term;
  end

endmodule
